writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Consumer end of the ALU's EXECUTE interface.
- Commits each registered EXECUTE result to architectural state: register file, PC, interrupt enable, saved PC, halt. Also issues the data-memory and IO write strobes.
- Runs on the same 4-cycle phase as the ALU.
- Publishes the STATE struct and register read ports back to decode/ALU.

Parameters:
- XLEN, 32, register/data width
- NREG, 16, number of registers (r0 hardwired zero)
- PC_W, 16, program counter width
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ex  in  EXECUTE  ALU result, registered by ALU on its phase-3 cycle
- irq  in  1  level interrupt request (used only with HALT_WAKE_EN)
- rs1_addr  in  $clog2(NREG)  read-port-1 address
- rs2_addr  in  $clog2(NREG)  read-port-2 address
- rs1_data  out  XLEN  combinational read data 1
- rs2_data  out  XLEN  combinational read data 2
- state  out  STATE  {pc, intr_en, saved_pc, halted}
- dmem_we  out  1  data-memory write strobe, one cycle
- dmem_addr  out  XLEN  data-memory write address
- dmem_wdata  out  XLEN  data-memory write data
- io_we  out  1  IO write strobe, one cycle
- io_wdata  out  XLEN  IO write data

Behaviour:
- EXECUTE fields consumed: rd_we, rd, rd_val, pc_next, mem_we, mem_addr, mem_wdata, io_we, io_wdata, intr_en_we, intr_en_val, save_pc, halt.
- Phase counter, 2 bits:
  - Reset to 0; increments every cycle; wraps 3→0.
  - Lockstep with the ALU counter, since both see the same reset.
  - Commit edge is the rising edge where phase==0, i.e. the first cycle the new ex is visible.
- primed flag:
  - Resets to 0; set at the first phase-0 edge.
  - That first phase-0 edge after reset does NOT commit; ex is the reset zero value.
- FSM states: RUN, HALT. Reset→RUN.
- RUN, commit edge with primed=1:
  - pc <= ex.pc_next[PC_W-1:0].
  - If ex.rd_we and ex.rd!=0: regs[ex.rd] <= ex.rd_val. Writes to r0 are dropped.
  - If ex.intr_en_we: intr_en <= ex.intr_en_val.
  - If ex.save_pc: saved_pc <= state.pc, the pre-update value.
  - dmem_we = ex.mem_we and io_we = ex.io_we, asserted for exactly the one cycle following the commit edge. Addr/data registered alongside.
  - If ex.halt: go to HALT, halted=1. pc is still updated to pc_next.
- HALT:
  - No commits; strobes stay 0; phase keeps counting.
  - Exits only via reset (see optional feature).
- Simultaneous events: intr_en_we and save_pc in the same commit are both applied (interrupt call). A halt ex still performs its own register write.
- Read ports are combinational. A read of the address being written at a commit edge returns the old value until that edge, the new value after.
- Reset values, asserted asynchronously, mid-operation included:
  - pc=RESET_PC, intr_en=0, saved_pc=0, halted=0.
  - All regs=0.
  - dmem_we=io_we=0; dmem_addr, dmem_wdata, io_wdata = 0.
  - phase=0, primed=0.

Optional Feature:
- Macro: WRITEBACK_HALT_WAKE_EN.
- Defined: in HALT, if irq=1 and intr_en=1 at a phase-0 edge, return to RUN and clear halted. No commit on that edge; the next ex (the ALU's icall) commits at the following phase-0 edge.
- Undefined: irq is ignored; HALT is left only by reset.

Decomposition:
- lib_cpu holds the STATE typedef and the EXECUTE field additions. New constants: RESET_PC, NREG, and the PHASE_COMMIT localparam (2'd0).
- lib_alu is not touched.
- Sub-module regfile: NREG×XLEN array, two combinational read ports, one synchronous write port with r0 masking, asynchronous clear.

Test Plan:
- Reset, then ex = 0 held → first phase-0 edge does not commit; pc stays 0; no strobes; the second phase-0 edge commits pc_next=0.
- ex {rd_we=1, rd=3, rd_val=32'hDEADBEEF, pc_next=16'h0004} → after the commit edge, rs1_addr=3 reads DEADBEEF and state.pc=0004. Same with rd=0 → rs1_addr=0 reads 0.
- ex {mem_we=1, mem_addr=32'h100, mem_wdata=32'h55} → dmem_we high for exactly 1 cycle, addr=100, data=55. Next ex with mem_we=0 → no strobe.
- ex {save_pc=1, intr_en_we=1, intr_en_val=0, pc_next=16'h0020} with pc=16'h0008 → saved_pc=0008, intr_en=0, pc=0020.
- ex {halt=1, pc_next=16'h000C} → halted=1, pc=000C. Later differing ex values cause no change. With WRITEBACK_HALT_WAKE_EN, intr_en=1 and irq=1 → halted clears at the next phase-0 edge.
- Assert reset asynchronously mid-phase (phase=2) after several commits → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared widths, EXECUTE/STATE types and FSM encoding for the writeback unit.
//   Contents: XLEN, NREG, PC_W, REG_AW, RESET_PC, PHASE_COMMIT,
//             execute_t (ALU -> writeback), state_t (writeback -> decode/ALU), wb_fsm_e.
package writeback_unit_pkg;
    localparam int XLEN   = 32;
    localparam int NREG   = 16;
    localparam int PC_W   = 16;
    localparam int REG_AW = $clog2(NREG);
    localparam logic [PC_W-1:0] RESET_PC     = 16'h0000;
    localparam logic [1:0]      PHASE_COMMIT = 2'd0;

    typedef struct packed {
        logic              rd_we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rd_val;
        logic [PC_W-1:0]   pc_next;
        logic              mem_we;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN-1:0]   mem_wdata;
        logic              io_we;
        logic [XLEN-1:0]   io_wdata;
        logic              intr_en_we;
        logic              intr_en_val;
        logic              save_pc;
        logic              halt;
    } execute_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            intr_en;
        logic [PC_W-1:0] saved_pc;
        logic            halted;
    } state_t;

    typedef enum logic {RUN, HALT} wb_fsm_e;
endpackage

// File: rtl/writeback_unit_regfile.sv
// writeback_unit_regfile: NREG x XLEN register file, r0 reads as zero.
//   Ports: clk, reset (async, active-high clear), we/waddr/wdata (sync write),
//          raddr1/raddr2 -> rdata1/rdata2 (combinational reads).
module writeback_unit_regfile
    import writeback_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);
    logic [XLEN-1:0] mem_q [NREG];

    // r0 is never written, so it holds its reset value of zero forever.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else if (we && waddr != '0) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: commits registered ALU EXECUTE results to architectural state on the phase-0 edge.
//   Ports: clk, reset (async, active-high), ex (EXECUTE from ALU), irq (level interrupt),
//          rs1_addr/rs2_addr -> rs1_data/rs2_data (combinational register reads),
//          state {pc, intr_en, saved_pc, halted}, dmem_we/dmem_addr/dmem_wdata and
//          io_we/io_wdata (one-cycle write strobes with registered address/data).
//   Build option: WRITEBACK_HALT_WAKE_EN lets irq with intr_en=1 leave HALT at a phase-0 edge.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  execute_t          ex,
    input  logic              irq,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output state_t            state,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic              io_we,
    output logic [XLEN-1:0]   io_wdata
);
    logic [1:0]      phase_q;
    logic            primed_q;
    wb_fsm_e         fsm_q, fsm_d;
    logic [PC_W-1:0] pc_q, pc_d, saved_q, saved_d;
    logic            intr_q, intr_d;
    logic            dmem_we_q, dmem_we_d, io_we_q, io_we_d;
    logic [XLEN-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d, io_wdata_q, io_wdata_d;
    logic            commit, wake;

    // The first phase-0 edge after reset only primes: ex still holds the ALU's reset value.
    assign commit = fsm_q == RUN && primed_q && phase_q == PHASE_COMMIT;

`ifdef WRITEBACK_HALT_WAKE_EN
    assign wake = fsm_q == HALT && phase_q == PHASE_COMMIT && irq && intr_q;
`else
    assign wake = irq & 1'b0;
`endif

    always_comb begin
        fsm_d        = wake ? RUN : (commit && ex.halt) ? HALT : fsm_q;
        pc_d         = commit ? ex.pc_next : pc_q;
        intr_d       = commit && ex.intr_en_we ? ex.intr_en_val : intr_q;
        saved_d      = commit && ex.save_pc ? pc_q : saved_q;
        dmem_we_d    = commit && ex.mem_we;
        io_we_d      = commit && ex.io_we;
        dmem_addr_d  = commit ? ex.mem_addr : dmem_addr_q;
        dmem_wdata_d = commit ? ex.mem_wdata : dmem_wdata_q;
        io_wdata_d   = commit ? ex.io_wdata : io_wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= '0;
            primed_q     <= 1'b0;
            fsm_q        <= RUN;
            pc_q         <= RESET_PC;
            intr_q       <= 1'b0;
            saved_q      <= '0;
            dmem_we_q    <= 1'b0;
            io_we_q      <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            io_wdata_q   <= '0;
        end else begin
            phase_q      <= phase_q + 2'd1;
            primed_q     <= primed_q | (phase_q == PHASE_COMMIT);
            fsm_q        <= fsm_d;
            pc_q         <= pc_d;
            intr_q       <= intr_d;
            saved_q      <= saved_d;
            dmem_we_q    <= dmem_we_d;
            io_we_q      <= io_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            io_wdata_q   <= io_wdata_d;
        end
    end

    writeback_unit_regfile u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (commit && ex.rd_we),
        .waddr  (ex.rd),
        .wdata  (ex.rd_val),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    assign state      = {pc_q, intr_q, saved_q, fsm_q == HALT};
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign io_we      = io_we_q;
    assign io_wdata   = io_wdata_q;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: randomized scoreboard bench for writeback_unit against an instruction-level model.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

`ifdef WRITEBACK_HALT_WAKE_EN
    localparam bit WAKE = 1'b1;
`else
    localparam bit WAKE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    execute_t          ex = '0;
    logic              irq = 1'b0;
    logic [REG_AW-1:0] rs1_addr = '0, rs2_addr = '0;
    logic [XLEN-1:0]   rs1_data, rs2_data, dmem_addr, dmem_wdata, io_wdata;
    state_t            state;
    logic              dmem_we, io_we;

    writeback_unit dut (
        .clk(clk), .reset(reset), .ex(ex), .irq(irq),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .state(state), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .io_we(io_we), .io_wdata(io_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0] pc, saved;
        logic            intr, halted, dwe, iwe;
        logic [XLEN-1:0] da, dd, id, r1, r2;
    } exp_t;

    exp_t            stq[$];
    exp_t            s;
    int              n_vec = 0, n_err = 0;
    logic            chk_now = 1'b0;
    logic [XLEN-1:0] mregs [NREG];
    logic [PC_W-1:0] m_pc, m_saved;
    logic            m_intr, m_halted;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Instruction-level reference: one EXECUTE record is one architectural step.
    task automatic model_apply(input execute_t e, input logic irq_v, input int a1, input int a2);
        exp_t r;
        r = '{default: '0};
        if (m_halted) begin
            if (WAKE && irq_v && m_intr) m_halted = 1'b0;
        end else begin
            r.dwe = e.mem_we; r.iwe = e.io_we;
            r.da = e.mem_addr; r.dd = e.mem_wdata; r.id = e.io_wdata;
            if (e.save_pc) m_saved = m_pc;
            m_pc = e.pc_next;
            if (e.rd_we && e.rd != 0) mregs[e.rd] = e.rd_val;
            if (e.intr_en_we) m_intr = e.intr_en_val;
            if (e.halt) m_halted = 1'b1;
        end
        r.pc = m_pc; r.saved = m_saved; r.intr = m_intr; r.halted = m_halted;
        r.r1 = mregs[a1]; r.r2 = mregs[a2];
        stq.push_back(r);
    endtask

    // Monitor: the cycle after every commit edge is checked against the oldest expectation;
    // a strobe in any other cycle is an error.
    always @(negedge clk) begin
        if (!reset && (dmem_we || io_we) && !chk_now)
            chk("stray_strobe", XLEN'({dmem_we, io_we}), '0);
        if (!reset && chk_now) begin
            if (stq.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                s = stq.pop_front();
                chk("pc", XLEN'(state.pc), XLEN'(s.pc));
                chk("saved_pc", XLEN'(state.saved_pc), XLEN'(s.saved));
                chk("intr_en", XLEN'(state.intr_en), XLEN'(s.intr));
                chk("halted", XLEN'(state.halted), XLEN'(s.halted));
                chk("dmem_we", XLEN'(dmem_we), XLEN'(s.dwe));
                chk("io_we", XLEN'(io_we), XLEN'(s.iwe));
                if (s.dwe) chk("dmem_addr", dmem_addr, s.da);
                if (s.dwe) chk("dmem_wdata", dmem_wdata, s.dd);
                if (s.iwe) chk("io_wdata", io_wdata, s.id);
                chk("rs1_data", rs1_data, s.r1);
                chk("rs2_data", rs2_data, s.r2);
            end
        end
    end

    // Asserts reset between clock edges, checks the immediate effect, releases it and
    // runs through the non-committing priming edge so the next call lands on a commit edge.
    task automatic do_reset();
        execute_t p;
        reset = 1'b1;
        #1;
        chk("rst_pc", XLEN'(state.pc), XLEN'(RESET_PC));
        chk("rst_intr", XLEN'(state.intr_en), 0);
        chk("rst_saved", XLEN'(state.saved_pc), 0);
        chk("rst_halted", XLEN'(state.halted), 0);
        chk("rst_dmem_we", XLEN'(dmem_we), 0);
        chk("rst_io_we", XLEN'(io_we), 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_io_wdata", io_wdata, 0);
        for (int i = 0; i < NREG; i++) begin
            rs1_addr = REG_AW'(i); rs2_addr = REG_AW'(NREG - 1 - i);
            #1;
            chk("rst_rs1", rs1_data, 0);
            chk("rst_rs2", rs2_data, 0);
        end
        stq.delete();
        m_pc = RESET_PC; m_saved = '0; m_intr = 1'b0; m_halted = 1'b0;
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        p = '0; p.pc_next = 16'h0044; p.mem_we = 1'b1; p.rd_we = 1'b1; p.rd = 4'd1; p.rd_val = 32'h1;
        ex = p;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("prime_pc", XLEN'(state.pc), XLEN'(RESET_PC));
        rs1_addr = REG_AW'(1);
        #1;
        chk("prime_r1", rs1_data, 0);
        ex = '0;
    endtask

    task automatic do_op(input execute_t e, input logic irq_v, input int a1, input int a2, input bit rst_mid);
        ex = e; irq = irq_v;
        rs1_addr = REG_AW'(a1); rs2_addr = REG_AW'(a2);
        model_apply(e, irq_v, a1, a2);
        @(posedge clk); #1 chk_now = 1'b1;
        @(posedge clk); #1 chk_now = 1'b0;
        if (rst_mid) do_reset();
        else begin
            @(posedge clk); @(posedge clk); #1;
        end
    endtask

    function automatic execute_t rand_ex();
        execute_t e;
        logic [31:0] r;
        r = $urandom;
        e.rd_we = r[0]; e.rd = r[4:1]; e.mem_we = r[6:5] == 0; e.io_we = r[8:7] == 0;
        e.intr_en_we = r[10:9] == 0; e.intr_en_val = r[11]; e.save_pc = r[13:12] == 0;
        e.halt = r[18:14] < 2; e.pc_next = r[31:16];
        e.rd_val = $urandom; e.mem_addr = $urandom; e.mem_wdata = $urandom; e.io_wdata = $urandom;
        return e;
    endfunction

    initial begin
        execute_t e;
        logic [31:0] r;
        do_reset();
        // Directed walk through the main commit cases.
        do_op('0, 1'b0, 0, 0, 1'b0);
        e = '0; e.rd_we = 1; e.rd = 3; e.rd_val = 32'hDEADBEEF; e.pc_next = 16'h0004;
        do_op(e, 1'b0, 3, 0, 1'b0);
        e.rd = 0; e.rd_val = 32'h12345678; e.pc_next = 16'h0008;
        do_op(e, 1'b0, 0, 3, 1'b0);
        e = '0; e.mem_we = 1; e.mem_addr = 32'h100; e.mem_wdata = 32'h55; e.pc_next = 16'h0008;
        do_op(e, 1'b0, 3, 0, 1'b0);
        e.mem_we = 0;
        do_op(e, 1'b0, 3, 0, 1'b0);
        e = '0; e.intr_en_we = 1; e.intr_en_val = 1; e.pc_next = 16'h0008;
        do_op(e, 1'b0, 3, 0, 1'b0);
        e = '0; e.save_pc = 1; e.intr_en_we = 1; e.intr_en_val = 0; e.pc_next = 16'h0020;
        do_op(e, 1'b0, 3, 0, 1'b0);
        e = '0; e.io_we = 1; e.io_wdata = 32'hA5A5_0F0F; e.mem_we = 1; e.mem_addr = 32'h204;
        e.mem_wdata = 32'h77; e.pc_next = 16'h0024;
        do_op(e, 1'b0, 3, 0, 1'b0);
        e = '0; e.halt = 1; e.pc_next = 16'h000C; e.rd_we = 1; e.rd = 5; e.rd_val = 32'hCAFE_F00D;
        do_op(e, 1'b0, 5, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            e = rand_ex(); e.mem_we = 1; e.rd_we = 1; e.rd = 7;
            do_op(e, 1'b1, 7, 5, 1'b0);
        end
        // Halt with interrupts enabled, then raise irq: wakes only when the option is built in.
        do_reset();
        e = '0; e.intr_en_we = 1; e.intr_en_val = 1; e.pc_next = 16'h0004;
        do_op(e, 1'b0, 0, 0, 1'b0);
        e = '0; e.halt = 1; e.pc_next = 16'h0008;
        do_op(e, 1'b0, 0, 0, 1'b0);
        e = '0; e.rd_we = 1; e.rd = 2; e.rd_val = 32'h1111; e.pc_next = 16'h0040;
        do_op(e, 1'b1, 2, 0, 1'b0);
        e = '0; e.rd_we = 1; e.rd = 4; e.rd_val = 32'h2222; e.pc_next = 16'h0044; e.io_we = 1;
        e.io_wdata = 32'h99;
        do_op(e, 1'b0, 4, 2, 1'b0);
        // Random rounds, each ending in a reset asserted mid-phase.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 60; i++) begin
                r = $urandom;
                do_op(rand_ex(), r[1:0] == 0, int'(r[7:4]), int'(r[11:8]), 1'b0);
            end
            r = $urandom;
            do_op(rand_ex(), 1'b0, int'(r[7:4]), int'(r[11:8]), 1'b1);
        end
        @(posedge clk); #1;
        chk("scoreboard_drained", XLEN'(stq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
